audio_stream_buffer: RTL and testbench

- Parametrised successor to the game-audio loopback controller.
- Sits between the codec's read/write handshake and the codec's DAC side, replacing the single-sample register with a DEPTH-entry stereo FIFO.
- Adds per-sample attenuation, mute, flush, and sticky overrun/underrun flags.
- Runs on the codec control clock and drives the codec's read/write strobes directly.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_sample_fifo.sv | 55 +++++
 rtl/audio_stream_buffer.sv | 135 +++++++++++++
 tb/tb_audio_stream_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types, default sizes and the attenuation helper for the audio stream buffer.
package audio_pkg;
  localparam int AUDIO_DATA_W = 24;
  localparam int AUDIO_DEPTH  = 8;
  localparam int AUDIO_VOL_W  = 3;

  // Helper operates on a wide signed container so any DATA_W/VOL_W fits.
  localparam int ATT_MAX_W = 64;
  localparam int ATT_SH_W  = 8;

  typedef enum logic {R_IDLE, R_STROBE} rd_state_t;
  typedef enum logic {W_IDLE, W_STROBE} wr_state_t;

  // Sign-preserving attenuation: arithmetic right shift.
  function automatic logic signed [ATT_MAX_W-1:0] attenuate(
    input logic signed [ATT_MAX_W-1:0] sample,
    input logic        [ATT_SH_W-1:0]  shift
  );
    return sample >>> shift;
  endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO: DEPTH entries, combinational head, synchronous flush.
module audio_sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  // Full/empty come from the registered count, so a full FIFO drops even with a concurrent pop.
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full  && !clear;
  assign w_do_pop  = pop  && !empty && !clear;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Sample storage, no reset needed: only read when occupied.
  always_ff @(posedge CLOCK_50) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/audio_stream_buffer.sv
// Codec loopback buffer: read FSM fills a stereo FIFO, write FSM drains it to the DAC
// with attenuation and mute. Define AUDIO_STREAM_MONO_EN to down-mix L/R to mono at pop.
module audio_stream_buffer
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W,
  parameter int DEPTH  = AUDIO_DEPTH,
  parameter int VOL_W  = AUDIO_VOL_W
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mute,
  input  logic                        clear,
  input  logic [VOL_W-1:0]            atten,
  input  logic                        read_ready,
  input  logic [DATA_W-1:0]           readdata_left,
  input  logic [DATA_W-1:0]           readdata_right,
  output logic                        read,
  input  logic                        write_ready,
  output logic                        write,
  output logic [DATA_W-1:0]           writedata_left,
  output logic [DATA_W-1:0]           writedata_right,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        overrun,
  output logic                        underrun
);
  localparam int CW = $clog2(DEPTH+1);

  rd_state_t r_rd_state, w_rd_next;
  wr_state_t r_wr_state, w_wr_next;

  logic [2*DATA_W-1:0]      w_head;
  logic                     w_full, w_empty, w_push, w_pop, w_wr_go, w_rd_drop;
  logic [CW-1:0]            w_count;
  logic signed [DATA_W-1:0] w_src_l, w_src_r;
  logic [DATA_W-1:0]        w_out_l, w_out_r;
  logic [DATA_W-1:0]        r_wd_l, r_wd_r;
  logic                     r_ovr, r_und;

  // Read strobe pushes (or drops when full); write launch pops at the same edge it leaves idle.
  assign w_push    = (r_rd_state == R_STROBE) && !w_full && !clear;
  assign w_rd_drop = (r_rd_state == R_STROBE) &&  w_full && !clear;
  assign w_wr_go   = (r_wr_state == W_IDLE) && write_ready && enable;
  assign w_pop     = w_wr_go && !w_empty && !clear;

  audio_sample_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .clear    (clear),
    .din      ({readdata_left, readdata_right}),
    .dout     (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

`ifdef AUDIO_STREAM_MONO_EN
  logic signed [DATA_W:0] w_sum;
  assign w_sum   = $signed({w_head[2*DATA_W-1], w_head[2*DATA_W-1:DATA_W]})
                 + $signed({w_head[DATA_W-1],   w_head[DATA_W-1:0]});
  assign w_src_l = DATA_W'(w_sum >>> 1);
  assign w_src_r = DATA_W'(w_sum >>> 1);
`else
  assign w_src_l = w_head[2*DATA_W-1:DATA_W];
  assign w_src_r = w_head[DATA_W-1:0];
`endif

  assign w_out_l = DATA_W'(attenuate(ATT_MAX_W'(w_src_l), ATT_SH_W'(atten)));
  assign w_out_r = DATA_W'(attenuate(ATT_MAX_W'(w_src_r), ATT_SH_W'(atten)));

  // FSM state registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
    end
  end

  // Next-state and strobes: each strobe lasts one cycle, then back to idle.
  always_comb begin
    w_rd_next = R_IDLE;
    w_wr_next = W_IDLE;
    read      = 1'b0;
    write     = 1'b0;
    case (r_rd_state)
      R_IDLE:   if (read_ready && enable) w_rd_next = R_STROBE;
      R_STROBE: read = 1'b1;
      default:  w_rd_next = R_IDLE;
    endcase
    case (r_wr_state)
      W_IDLE:   if (w_wr_go) w_wr_next = W_STROBE;
      W_STROBE: write = 1'b1;
      default:  w_wr_next = W_IDLE;
    endcase
  end

  // DAC sample register and sticky flags; clear wins over new flag events.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_wd_l <= '0;
      r_wd_r <= '0;
      r_ovr  <= 1'b0;
      r_und  <= 1'b0;
    end else begin
      if (w_wr_go) begin
        if (clear || w_empty || mute) begin
          r_wd_l <= '0;
          r_wd_r <= '0;
        end else begin
          r_wd_l <= w_out_l;
          r_wd_r <= w_out_r;
        end
      end
      if (clear) begin
        r_ovr <= 1'b0;
        r_und <= 1'b0;
      end else begin
        if (w_rd_drop)          r_ovr <= 1'b1;
        if (w_wr_go && w_empty) r_und <= 1'b1;
      end
    end
  end

  assign writedata_left  = r_wd_l;
  assign writedata_right = r_wd_r;
  assign fifo_count      = w_count;
  assign overrun         = r_ovr;
  assign underrun        = r_und;
endmodule

// File: tb/tb_audio_stream_buffer.sv
// Scoreboard bench for audio_stream_buffer: queue-based reference model, negedge monitor.
module tb_audio_stream_buffer;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;
  localparam int VOL_W  = 3;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0, mute = 1'b0, clear = 1'b0;
  logic [VOL_W-1:0] atten = '0;
  logic read_ready = 1'b0, write_ready = 1'b0;
  logic [DATA_W-1:0] readdata_left = '0, readdata_right = '0;
  logic read, write, overrun, underrun;
  logic [DATA_W-1:0] writedata_left, writedata_right;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  audio_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .VOL_W(VOL_W)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .mute(mute), .clear(clear),
    .atten(atten), .read_ready(read_ready), .readdata_left(readdata_left),
    .readdata_right(readdata_right), .read(read), .write_ready(write_ready),
    .write(write), .writedata_left(writedata_left), .writedata_right(writedata_right),
    .fifo_count(fifo_count), .overrun(overrun), .underrun(underrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  logic [2*DATA_W-1:0] m_q[$];
  logic [2*DATA_W-1:0] exp_q[$];
  bit m_rd = 0, m_wr = 0, m_ovr = 0, m_und = 0;

  function automatic int fdiv(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Floor-divide by 2^atten (optionally after mono averaging), zero when muted.
  function automatic logic [2*DATA_W-1:0] process(input logic [2*DATA_W-1:0] pr,
                                                  input logic [VOL_W-1:0] a, input logic mu);
    logic signed [DATA_W-1:0] sl, sr;
    int l, r, d;
    sl = pr[2*DATA_W-1:DATA_W];
    sr = pr[DATA_W-1:0];
    l = sl;
    r = sr;
    d = 1 << a;
`ifdef AUDIO_STREAM_MONO_EN
    l = fdiv(l + r, 2);
    r = l;
`endif
    l = fdiv(l, d);
    r = fdiv(r, d);
    if (mu) return '0;
    return {DATA_W'(l), DATA_W'(r)};
  endfunction

  // Model advances on the same edges as the DUT, from the inputs held since the last edge.
  always @(posedge CLOCK_50 or negedge reset) begin : mdl
    bit was_full, was_empty, go;
    logic [2*DATA_W-1:0] head;
    if (!reset) begin
      m_q.delete(); exp_q.delete();
      m_rd = 0; m_wr = 0; m_ovr = 0; m_und = 0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      go = !m_wr && write_ready && enable;
      if (go) begin
        if (clear || was_empty) exp_q.push_back('0);
        else begin
          head = m_q.pop_front();
          exp_q.push_back(process(head, atten, mute));
        end
        if (!clear && was_empty) m_und = 1;
      end
      if (m_rd && !clear) begin
        if (was_full) m_ovr = 1;
        else m_q.push_back({readdata_left, readdata_right});
      end
      if (clear) begin
        m_q.delete(); m_ovr = 0; m_und = 0;
      end
      m_rd = !m_rd && read_ready && enable;
      m_wr = go;
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each write strobe.
  always @(negedge CLOCK_50) begin : mon
    logic [2*DATA_W-1:0] e;
    if (mon_en) begin
      chk("read", 64'(read), 64'(m_rd));
      chk("write", 64'(write), 64'(m_wr));
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("underrun", 64'(underrun), 64'(m_und));
      if (!reset) begin
        chk("rst_wd_left", 64'(writedata_left), 64'(0));
        chk("rst_wd_right", 64'(writedata_right), 64'(0));
      end
      if (write) begin
        if (exp_q.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("wd_left", 64'(writedata_left), 64'(e[2*DATA_W-1:DATA_W]));
          chk("wd_right", 64'(writedata_right), 64'(e[DATA_W-1:0]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic drive(input logic rr, input logic wr, input logic en, input logic mu,
                       input logic cl, input logic [VOL_W-1:0] at,
                       input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int n);
    read_ready = rr; write_ready = wr; enable = en; mute = mu; clear = cl;
    atten = at; readdata_left = l; readdata_right = r;
    step(n);
  endtask

  initial begin
    step(3);
    reset = 1'b1;
    mon_en = 1'b1;
    step(1);
    // Three reads of a known pair, then drain three writes.
    drive(1, 0, 1, 0, 0, 0, 24'h100000, 24'hF00000, 6);
    drive(0, 1, 1, 0, 0, 0, 24'h0, 24'h0, 6);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Attenuation on a negative full-scale sample, then a muted sample.
    drive(1, 0, 1, 0, 0, 4, 24'h800000, 24'h7FFFF0, 2);
    drive(0, 1, 1, 0, 0, 4, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(1, 0, 1, 0, 0, 0, 24'h123456, 24'h654321, 2);
    drive(0, 1, 1, 1, 0, 0, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Mono-mix pair (plain pass-through when mono is off).
    drive(1, 0, 1, 0, 0, 0, 24'h000100, 24'h000300, 2);
    drive(0, 1, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Overfill to force overrun, then flush.
    drive(1, 0, 1, 0, 0, 0, 24'h0ABCDE, 24'h0FEDCB, 20);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 1, 0, 24'h0, 24'h0, 1);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Write from an empty FIFO: silence plus underrun.
    drive(0, 1, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(0, 0, 1, 0, 1, 0, 24'h0, 24'h0, 1);
    // Fill to 4, then aligned push/pop keeps the count at 4.
    drive(1, 0, 1, 0, 0, 0, 24'h111111, 24'h222222, 8);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    drive(1, 1, 1, 0, 0, 2, 24'h333333, 24'hC44444, 12);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Reach 5 entries, then an asynchronous reset mid-stream.
    drive(1, 0, 1, 0, 0, 0, 24'h555555, 24'h666666, 2);
    drive(1, 0, 1, 0, 0, 0, 24'h777777, 24'h888888, 1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 2);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 2), VOL_W'($urandom()),
            DATA_W'($urandom()), DATA_W'($urandom()), 1);
    end
    // Drain everything so every scoreboard entry gets consumed.
    drive(0, 1, 1, 0, 0, 0, 24'h0, 24'h0, 30);
    drive(0, 0, 1, 0, 0, 0, 24'h0, 24'h0, 4);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
